// File: rtl/ccr_controller.sv
// Condition code register (Z,N,C) with nested interrupt save/restore.
// Optional macro CCR_BYPASS_EN: ccr_fwd shows the next-edge CCR value.
module ccr_controller #(
  parameter int SAVE_DEPTH = 2,
  parameter int INT_HOLD   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        stall,
  input  logic [12:0] alu_operation,
  input  logic [15:0] alu_result,
  input  logic [2:0]  alu_flag,
  input  logic        setc,
  input  logic        clrc,
  input  logic        jz_taken,
  input  logic        jn_taken,
  input  logic        jc_taken,
  input  logic        int_req,
  input  logic        rti,
  output logic [2:0]  ccr,
  output logic [2:0]  ccr_fwd,
  output logic        busy,
  output logic [2:0]  save_cnt,
  output logic        err,
  output logic        op_err
);

  localparam int IW = (SAVE_DEPTH > 1) ? $clog2(SAVE_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, SAVE, HOLD, RESTORE} state_t;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_ccr, w_ccr_nxt, w_ccr_upd;
  logic [2:0]    r_slot [SAVE_DEPTH];
  logic [2:0]    r_save_cnt, w_cnt_nxt;
  logic [2:0]    r_hold, w_hold_nxt;
  logic          r_pend, w_pend_nxt;
  logic          r_err, w_err_nxt;
  logic          r_op_err;
  logic          w_push, w_exe, w_multi, w_onehot, w_op_err;
  logic [IW-1:0] w_push_idx, w_pop_idx;

  assign w_exe      = ex_valid & ~stall;
  assign w_multi    = |(alu_operation & (alu_operation - 13'd1));
  assign w_onehot   = (|alu_operation) & ~w_multi;
  assign w_op_err   = (setc & clrc) | (w_exe & w_multi);
  assign w_push_idx = r_save_cnt[IW-1:0];
  assign w_pop_idx  = IW'(r_save_cnt - 3'd1);

  // Later assignments override earlier: ALU < jump clear < setc/clrc
  always_comb begin
    w_ccr_upd = r_ccr;
    if (w_exe && w_onehot) begin
      unique case (1'b1)
        alu_operation[7], alu_operation[1],
        alu_operation[3], alu_operation[2]:
          w_ccr_upd = {alu_flag[2], alu_result[15],
                       ~|alu_result};
        alu_operation[6], alu_operation[0],
        alu_operation[9], alu_operation[5],
        alu_operation[4]:
          w_ccr_upd[1:0] = {alu_result[15], ~|alu_result};
        default: ;
      endcase
    end
    if (w_exe) begin
      if (jz_taken) w_ccr_upd[0] = 1'b0;
      if (jn_taken) w_ccr_upd[1] = 1'b0;
      if (jc_taken) w_ccr_upd[2] = 1'b0;
    end
    if (setc && !clrc) w_ccr_upd[2] = 1'b1;
    if (clrc && !setc) w_ccr_upd[2] = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ccr_nxt   = r_ccr;
    w_cnt_nxt   = r_save_cnt;
    w_hold_nxt  = r_hold;
    w_pend_nxt  = r_pend;
    w_err_nxt   = r_err;
    w_push      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ccr_nxt = w_ccr_upd;
        if (r_pend) begin
          w_state_nxt = SAVE;
          w_pend_nxt  = int_req;
        end else if (int_req && rti) begin
          w_state_nxt = RESTORE;
          w_pend_nxt  = 1'b1;
        end else if (int_req) begin
          w_state_nxt = SAVE;
        end else if (rti) begin
          w_state_nxt = RESTORE;
        end
      end
      SAVE: begin
        if (r_save_cnt < 3'(SAVE_DEPTH)) begin
          w_push    = 1'b1;
          w_cnt_nxt = r_save_cnt + 3'd1;
        end else begin
          w_err_nxt = 1'b1;
        end
        if (int_req) w_pend_nxt = 1'b1;
        if (INT_HOLD == 0) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = HOLD;
          w_hold_nxt  = 3'(INT_HOLD - 1);
        end
      end
      HOLD: begin
        if (int_req) w_pend_nxt = 1'b1;
        if (r_hold == 3'd0) w_state_nxt = IDLE;
        else                w_hold_nxt  = r_hold - 3'd1;
      end
      RESTORE: begin
        if (r_save_cnt != 3'd0) begin
          w_ccr_nxt = r_slot[w_pop_idx];
          w_cnt_nxt = r_save_cnt - 3'd1;
        end else begin
          w_err_nxt = 1'b1;
        end
        if (r_pend || int_req) begin
          w_state_nxt = SAVE;
          w_pend_nxt  = 1'b0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ccr      <= 3'd0;
      r_save_cnt <= 3'd0;
      r_hold     <= 3'd0;
      r_pend     <= 1'b0;
      r_err      <= 1'b0;
      r_op_err   <= 1'b0;
      for (int i = 0; i < SAVE_DEPTH; i++) r_slot[i] <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_ccr      <= w_ccr_nxt;
      r_save_cnt <= w_cnt_nxt;
      r_hold     <= w_hold_nxt;
      r_pend     <= w_pend_nxt;
      r_err      <= w_err_nxt;
      r_op_err   <= w_op_err;
      if (w_push) r_slot[w_push_idx] <= r_ccr;
    end
  end

  assign ccr      = r_ccr;
  assign busy     = (r_state != IDLE);
  assign save_cnt = r_save_cnt;
  assign err      = r_err;
  assign op_err   = r_op_err;

`ifdef CCR_BYPASS_EN
  assign ccr_fwd = w_ccr_nxt;
`else
  assign ccr_fwd = r_ccr;
`endif

endmodule

// File: tb/tb_ccr_controller.sv
// Bench for ccr_controller: vector table through a scoreboard queue,
// then hand-written interrupt/RTI/reset sequences.
module tb_ccr_controller;

  localparam logic L0 = 1'b0;
  localparam logic L1 = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, stall;
  logic [12:0] alu_operation;
  logic [15:0] alu_result;
  logic [2:0]  alu_flag;
  logic        setc, clrc, jz_taken, jn_taken, jc_taken;
  logic        int_req, rti;
  logic [2:0]  ccr, ccr_fwd, save_cnt;
  logic        busy, err, op_err;

  int checks = 0;
  int fails  = 0;

  ccr_controller #(.SAVE_DEPTH(2), .INT_HOLD(2)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .stall(stall),
    .alu_operation(alu_operation), .alu_result(alu_result),
    .alu_flag(alu_flag), .setc(setc), .clrc(clrc),
    .jz_taken(jz_taken), .jn_taken(jn_taken), .jc_taken(jc_taken),
    .int_req(int_req), .rti(rti), .ccr(ccr), .ccr_fwd(ccr_fwd),
    .busy(busy), .save_cnt(save_cnt), .err(err), .op_err(op_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ev, st;
    logic [12:0] op;
    logic [15:0] res;
    logic [2:0]  flg;
    logic        sc, cc, jz, jn, jc;
    logic [2:0]  eccr;
    logic        eop;
  } vec_t;

  typedef struct {
    logic [2:0] ccr;
    logic       oe;
  } exp_t;

  vec_t vt[19];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [2:0] act,
                     input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%b expected=%b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_valid = 0; stall = 0; alu_operation = '0; alu_result = '0;
    alu_flag = '0; setc = 0; clrc = 0; jz_taken = 0; jn_taken = 0;
    jc_taken = 0; int_req = 0; rti = 0;
  endtask

  task automatic alu(input logic [12:0] op, input logic [15:0] res,
                     input logic [2:0] flg);
    ex_valid = 1; alu_operation = op; alu_result = res; alu_flag = flg;
    tick();
    idle_in();
  endtask

  task automatic pulse_int(input logic r);
    int_req = 1; rti = r;
    tick();
    idle_in();
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_ccr"}, ccr, 3'b000);
    chk({nm, "_fwd"}, ccr_fwd, 3'b000);
    chk({nm, "_cnt"}, save_cnt, 3'd0);
    chk({nm, "_busy"}, {2'b00, busy}, 3'd0);
    chk({nm, "_err"}, {2'b00, err}, 3'd0);
    chk({nm, "_operr"}, {2'b00, op_err}, 3'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    //       ev  st  op        res       flg     sc  cc  jz  jn  jc  ccr     oe
    vt[0]  = '{L1, L0, 13'h0080, 16'h0000, 3'b100, L0, L0, L0, L0, L0, 3'b101, L0};
    vt[1]  = '{L1, L0, 13'h0040, 16'h8001, 3'b000, L0, L0, L0, L0, L0, 3'b110, L0};
    vt[2]  = '{L1, L1, 13'h0040, 16'h0000, 3'b000, L0, L0, L0, L0, L0, 3'b110, L0};
    vt[3]  = '{L0, L0, 13'h0040, 16'h0000, 3'b000, L0, L0, L0, L0, L0, 3'b110, L0};
    vt[4]  = '{L0, L0, 13'h0000, 16'h0000, 3'b000, L0, L1, L0, L0, L0, 3'b010, L0};
    vt[5]  = '{L0, L0, 13'h0000, 16'h0000, 3'b000, L1, L0, L0, L0, L0, 3'b110, L0};
    vt[6]  = '{L0, L0, 13'h0000, 16'h0000, 3'b000, L1, L1, L0, L0, L0, 3'b110, L1};
    vt[7]  = '{L1, L0, 13'h0100, 16'h0000, 3'b000, L0, L0, L0, L0, L0, 3'b110, L0};
    vt[8]  = '{L1, L0, 13'h0080, 16'h1234, 3'b000, L0, L0, L0, L0, L0, 3'b000, L0};
    vt[9]  = '{L1, L0, 13'h0001, 16'hFFFF, 3'b100, L0, L0, L0, L0, L0, 3'b010, L0};
    vt[10] = '{L1, L0, 13'h0002, 16'h0000, 3'b100, L0, L0, L0, L0, L0, 3'b101, L0};
    vt[11] = '{L1, L0, 13'h0020, 16'h0000, 3'b000, L0, L0, L1, L0, L0, 3'b100, L0};
    vt[12] = '{L1, L0, 13'h0180, 16'h0000, 3'b000, L0, L0, L0, L0, L0, 3'b100, L1};
    vt[13] = '{L1, L0, 13'h0000, 16'h0000, 3'b000, L0, L0, L0, L0, L0, 3'b100, L0};
    vt[14] = '{L1, L0, 13'h0010, 16'h8000, 3'b000, L0, L0, L0, L1, L1, 3'b000, L0};
    vt[15] = '{L1, L0, 13'h0080, 16'h0000, 3'b000, L1, L0, L0, L0, L1, 3'b101, L0};
    vt[16] = '{L1, L1, 13'h0003, 16'h0000, 3'b000, L0, L0, L0, L0, L0, 3'b101, L0};
    vt[17] = '{L1, L0, 13'h0200, 16'h8000, 3'b000, L0, L0, L0, L0, L0, 3'b110, L0};
    vt[18] = '{L1, L0, 13'h0004, 16'h4000, 3'b000, L0, L0, L0, L0, L0, 3'b000, L0};

    idle_in();
    rst_n = 0;
    #1;
    check_reset("rst_init");
    tick();
    tick();
    rst_n = 1;
    tick();

    for (int i = 0; i < 19; i++) begin
      ex_valid = vt[i].ev; stall = vt[i].st; alu_operation = vt[i].op;
      alu_result = vt[i].res; alu_flag = vt[i].flg;
      setc = vt[i].sc; clrc = vt[i].cc; jz_taken = vt[i].jz;
      jn_taken = vt[i].jn; jc_taken = vt[i].jc;
      sb.push_back('{vt[i].eccr, vt[i].eop});
      tick();
      e = sb.pop_front();
      chk($sformatf("vec%0d_ccr", i), ccr, e.ccr);
      chk($sformatf("vec%0d_operr", i), {2'b00, op_err}, {2'b00, e.oe});
`ifndef CCR_BYPASS_EN
      chk($sformatf("vec%0d_fwd", i), ccr_fwd, e.ccr);
`endif
    end
    idle_in();
    tick();
    chk("operr_clear", {2'b00, op_err}, 3'd0);

    // nested saves, overflow
    alu(13'h0001, 16'hFFFF, 3'b000);
    chk("pre_save_ccr", ccr, 3'b010);
    pulse_int(1'b0);
    chk("save_busy1", {2'b00, busy}, 3'd1);
    tick();
    chk("save_busy2", {2'b00, busy}, 3'd1);
    chk("save_cnt1", save_cnt, 3'd1);
    setc = 1;
    tick();
    idle_in();
    chk("hold_busy3", {2'b00, busy}, 3'd1);
    chk("hold_ignores_setc", ccr, 3'b010);
    tick();
    chk("hold_done", {2'b00, busy}, 3'd0);
    alu(13'h0080, 16'h0000, 3'b000);
    chk("pre_save2_ccr", ccr, 3'b001);
    pulse_int(1'b0);
    repeat (3) tick();
    chk("save_cnt2", save_cnt, 3'd2);
    chk("no_err_yet", {2'b00, err}, 3'd0);
    pulse_int(1'b0);
    tick();
    chk("ovf_err", {2'b00, err}, 3'd1);
    chk("ovf_cnt", save_cnt, 3'd2);
    repeat (2) tick();

    // restores
    rti = 1; tick(); idle_in(); tick();
    chk("rti1_ccr", ccr, 3'b001);
    chk("rti1_cnt", save_cnt, 3'd1);
    chk("rti1_busy", {2'b00, busy}, 3'd0);
    rti = 1; tick(); idle_in(); tick();
    chk("rti2_ccr", ccr, 3'b010);
    chk("rti2_cnt", save_cnt, 3'd0);

    // reset clears sticky err; then underflow
    rst_n = 0;
    #1;
    check_reset("rst_after_err");
    tick();
    rst_n = 1;
    tick();
    alu(13'h0001, 16'hFFFF, 3'b000);
    rti = 1; tick(); idle_in(); tick();
    chk("unf_ccr", ccr, 3'b010);
    chk("unf_err", {2'b00, err}, 3'd1);
    chk("unf_cnt", save_cnt, 3'd0);

    rst_n = 0; tick(); rst_n = 1; tick();

    // simultaneous int_req + rti
    setc = 1; tick(); idle_in();
    pulse_int(1'b0);
    repeat (3) tick();
    chk("sim_pre_cnt", save_cnt, 3'd1);
    alu(13'h0080, 16'h0000, 3'b000);
    chk("sim_pre_ccr", ccr, 3'b001);
    pulse_int(1'b1);
    chk("sim_busy", {2'b00, busy}, 3'd1);
    tick();
    chk("sim_restore_ccr", ccr, 3'b100);
    chk("sim_restore_cnt", save_cnt, 3'd0);
    chk("sim_restore_busy", {2'b00, busy}, 3'd1);
    tick();
    chk("sim_save_cnt", save_cnt, 3'd1);
    repeat (2) tick();
    chk("sim_done_busy", {2'b00, busy}, 3'd0);
    chk("sim_done_err", {2'b00, err}, 3'd0);
    clrc = 1; tick(); idle_in();
    chk("sim_clrc", ccr, 3'b000);
    rti = 1; tick(); idle_in(); tick();
    chk("sim_slot", ccr, 3'b100);

    // async reset in the middle of HOLD
    pulse_int(1'b0);
    tick();
    chk("mid_hold_busy", {2'b00, busy}, 3'd1);
    #3;
    rst_n = 0;
    #1;
    check_reset("rst_mid_hold");
    tick();
    rst_n = 1;
    tick();
    chk("post_rst_idle", {2'b00, busy}, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
